// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin icache/dcache arbiter onto a single-outstanding main memory port
module mem_arbiter #(
    parameter int ARCH_LEN  = 32,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_req_valid,
    input  logic [ARCH_LEN-1:0]  ic_req_addr,
    output logic                 ic_req_ready,
    input  logic                 ic_kill,
    output logic                 ic_resp_valid,
    output logic [LINE_BITS-1:0] ic_resp_data,
    input  logic                 dc_req_valid,
    input  logic                 dc_req_we,
    input  logic [ARCH_LEN-1:0]  dc_req_addr,
    input  logic [LINE_BITS-1:0] dc_req_wdata,
    output logic                 dc_req_ready,
    output logic                 dc_resp_valid,
    output logic [LINE_BITS-1:0] dc_resp_data,
    output logic                 mem_req_valid,
    output logic                 mem_req_we,
    output logic [ARCH_LEN-1:0]  mem_req_addr,
    output logic [LINE_BITS-1:0] mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;
    logic last_grant;
    logic owner_dc;
    logic drop;
    logic sel_dc;
    logic ic_acc;
    logic dc_acc;
    // grant: dcache wins alone, or on a tie when the icache was granted last
    always_comb begin
        sel_dc       = dc_req_valid & (~ic_req_valid | ~last_grant);
        ic_req_ready = ~rst & (state == IDLE) & ic_req_valid & ~sel_dc;
        dc_req_ready = ~rst & (state == IDLE) & sel_dc;
        ic_acc       = ic_req_ready & ic_req_valid;
        dc_acc       = dc_req_ready & dc_req_valid;
    end
    // transaction FSM; the latched request fields double as the memory request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b0;
            owner_dc      <= 1'b0;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
        end else begin
            mem_req_valid <= 1'b0;
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            case (state)
                IDLE: if (ic_acc | dc_acc) begin
                    owner_dc      <= dc_acc;
                    last_grant    <= dc_acc;
                    drop          <= ic_acc & ic_kill;
                    mem_req_valid <= 1'b1;
                    mem_req_we    <= dc_acc & dc_req_we;
                    mem_req_addr  <= dc_acc ? dc_req_addr : ic_req_addr;
                    mem_req_wdata <= dc_acc ? dc_req_wdata : '0;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (~owner_dc & ic_kill) drop <= 1'b1;
                    state <= WAIT;
                end
                WAIT: if (mem_resp_valid) begin
                    if (owner_dc) begin
                        dc_resp_valid <= 1'b1;
                        dc_resp_data  <= mem_req_we ? '0 : mem_resp_data;
                    end else if (~drop & ~ic_kill) begin
                        ic_resp_valid <= 1'b1;
                        ic_resp_data  <= mem_resp_data;
                    end
                    drop  <= 1'b0;
                    state <= IDLE;
                end else if (~owner_dc & ic_kill) begin
                    drop <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req_valid = 1'b0;
    logic [31:0]  ic_req_addr = '0;
    logic         ic_req_ready;
    logic         ic_kill = 1'b0;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid = 1'b0;
    logic         dc_req_we = 1'b0;
    logic [31:0]  dc_req_addr = '0;
    logic [127:0] dc_req_wdata = '0;
    logic         dc_req_ready;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_data;
    logic         mem_req_valid;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;
    int n_checks = 0;
    int n_fail = 0;
    localparam logic [127:0] A5 = {16{8'hA5}};
    mem_arbiter #(.ARCH_LEN(32), .LINE_BITS(128)) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_kill(ic_kill), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        #1;
        n_checks++; if (ic_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ic_ready: got %b want 0", ic_req_ready); end
        n_checks++; if (dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dc_ready: got %b want 0", dc_req_ready); end
        n_checks++; if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 128'h0) begin n_fail++; $display("FAIL rst_mem_req: got v=%b we=%b a=%h", mem_req_valid, mem_req_we, mem_req_addr); end
        n_checks++; if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got ic=%b dc=%b want 0 0", ic_resp_valid, dc_resp_valid); end
        n_checks++; if (ic_resp_data !== 128'h0 || dc_resp_data !== 128'h0) begin n_fail++; $display("FAIL rst_resp_data: got ic=%h dc=%h want 0", ic_resp_data, dc_resp_data); end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask
    task automatic test_ic_fill();
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h100;
        #1;
        n_checks++; if (ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got ic=%b dc=%b want 1 0", ic_req_ready, dc_req_ready); end
        tick();
        ic_req_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL fill_issue: got v=%b we=%b a=%h want 1 0 100", mem_req_valid, mem_req_we, mem_req_addr); end
        tick();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fill_issue_pulse: got %b want 0", mem_req_valid); end
        tick();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = A5;
        #1;
        n_checks++; if (ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_resp: got %b want 0", ic_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (ic_resp_valid !== 1'b1 || ic_resp_data !== A5 || dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_resp: got v=%b d=%h dcv=%b want 1 %h 0", ic_resp_valid, ic_resp_data, dc_resp_valid, A5); end
        tick();
        n_checks++; if (ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_resp_pulse: got %b want 0", ic_resp_valid); end
    endtask
    task automatic test_arbitration();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h300;
        dc_req_valid = 1'b1;
        dc_req_addr = 32'h400;
        #1;
        n_checks++; if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_first: got ic=%b dc=%b want 0 1", ic_req_ready, dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400 || ic_req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_dc_issue: got v=%b a=%h icr=%b want 1 400 0", mem_req_valid, mem_req_addr, ic_req_ready); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h1111;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (dc_resp_valid !== 1'b1 || dc_resp_data !== 128'h1111) begin n_fail++; $display("FAIL arb_dc_resp: got v=%b d=%h want 1 1111", dc_resp_valid, dc_resp_data); end
        n_checks++; if (ic_req_ready !== 1'b1) begin n_fail++; $display("FAIL arb_ic_after_dc: got %b want 1", ic_req_ready); end
        tick();
        ic_req_valid = 1'b0;
        n_checks++; if (mem_req_addr !== 32'h300 || mem_req_we !== 1'b0) begin n_fail++; $display("FAIL arb_ic_issue: got a=%h we=%b want 300 0", mem_req_addr, mem_req_we); end
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h310;
        dc_req_valid = 1'b1;
        dc_req_addr = 32'h410;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h2222;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ic_resp_valid !== 1'b1 || ic_resp_data !== 128'h2222 || dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL arb_ic_resp: got v=%b d=%h dcv=%b want 1 2222 0", ic_resp_valid, ic_resp_data, dc_resp_valid); end
        n_checks++; if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_alt_dc: got ic=%b dc=%b want 0 1", ic_req_ready, dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        n_checks++; if (mem_req_addr !== 32'h410) begin n_fail++; $display("FAIL arb_alt_dc_issue: got %h want 410", mem_req_addr); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h3333;
        tick();
        mem_resp_valid = 1'b0;
        dc_req_valid = 1'b1;
        dc_req_addr = 32'h420;
        #1;
        n_checks++; if (ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_alt_ic: got ic=%b dc=%b want 1 0", ic_req_ready, dc_req_ready); end
        tick();
        ic_req_valid = 1'b0;
        n_checks++; if (mem_req_addr !== 32'h310) begin n_fail++; $display("FAIL arb_alt_ic_issue: got %h want 310", mem_req_addr); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h4444;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (dc_req_ready !== 1'b1) begin n_fail++; $display("FAIL arb_alt_dc2: got %b want 1", dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        n_checks++; if (mem_req_addr !== 32'h420) begin n_fail++; $display("FAIL arb_alt_dc2_issue: got %h want 420", mem_req_addr); end
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
    endtask
    task automatic test_writeback();
        dc_req_valid = 1'b1;
        dc_req_we = 1'b1;
        dc_req_addr = 32'h200;
        dc_req_wdata = 128'h1234;
        #1;
        n_checks++; if (dc_req_ready !== 1'b1) begin n_fail++; $display("FAIL wb_ready: got %b want 1", dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        dc_req_we = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 32'h200 || mem_req_wdata !== 128'h1234) begin n_fail++; $display("FAIL wb_issue: got v=%b we=%b a=%h wd=%h want 1 1 200 1234", mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = {4{32'hFFFF_FFFF}};
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (dc_resp_valid !== 1'b1 || dc_resp_data !== 128'h0 || ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL wb_ack: got v=%b d=%h icv=%b want 1 0 0", dc_resp_valid, dc_resp_data, ic_resp_valid); end
    endtask
    task automatic test_kill();
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h500;
        tick();
        ic_req_valid = 1'b0;
        tick();
        ic_kill = 1'b1;
        tick();
        ic_kill = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h77;
        dc_req_valid = 1'b1;
        dc_req_addr = 32'h600;
        #1;
        n_checks++; if (dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL kill_wait_ready: got %b want 0", dc_req_ready); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_dropped: got %b want 0", ic_resp_valid); end
        n_checks++; if (dc_req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_dc_queued: got %b want 1", dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h600) begin n_fail++; $display("FAIL kill_dc_issue: got v=%b a=%h want 1 600", mem_req_valid, mem_req_addr); end
        tick();
        ic_kill = 1'b1;
        tick();
        ic_kill = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h88;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (dc_resp_valid !== 1'b1 || dc_resp_data !== 128'h88 || ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_dc_unaffected: got v=%b d=%h icv=%b want 1 88 0", dc_resp_valid, dc_resp_data, ic_resp_valid); end
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h540;
        tick();
        ic_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h99;
        ic_kill = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        ic_kill = 1'b0;
        n_checks++; if (ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_completion: got %b want 0", ic_resp_valid); end
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h580;
        tick();
        ic_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'hAB;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (ic_resp_valid !== 1'b1 || ic_resp_data !== 128'hAB) begin n_fail++; $display("FAIL kill_flag_cleared: got v=%b d=%h want 1 ab", ic_resp_valid, ic_resp_data); end
    endtask
    task automatic test_reset_mid();
        ic_req_valid = 1'b1;
        ic_req_addr = 32'h700;
        tick();
        ic_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        #1;
        n_checks++; if (ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got ic=%b dc=%b want 0 0", ic_req_ready, dc_req_ready); end
        rst = 1'b0;
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h5555;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_resp: got ic=%b dc=%b mv=%b want 0 0 0", ic_resp_valid, dc_resp_valid, mem_req_valid); end
        ic_req_valid = 1'b1;
        #1;
        n_checks++; if (ic_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_resume: got %b want 1", ic_req_ready); end
        ic_req_valid = 1'b0;
        tick();
    endtask
    task automatic test_spurious();
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'hDEAD;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_valid: got ic=%b dc=%b mv=%b want 0 0 0", ic_resp_valid, dc_resp_valid, mem_req_valid); end
        n_checks++; if (ic_resp_data !== 128'h0 || dc_resp_data !== 128'h0) begin n_fail++; $display("FAIL spur_idle_data: got ic=%h dc=%h want 0 0", ic_resp_data, dc_resp_data); end
        dc_req_valid = 1'b1;
        dc_req_addr = 32'h800;
        #1;
        n_checks++; if (dc_req_ready !== 1'b1) begin n_fail++; $display("FAIL spur_idle_state: got %b want 1", dc_req_ready); end
        tick();
        dc_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h11;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL spur_issue: got %b want 0", dc_resp_valid); end
        tick();
        n_checks++; if (dc_resp_valid !== 1'b0 || dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL spur_still_wait: got v=%b r=%b want 0 0", dc_resp_valid, dc_req_ready); end
        mem_resp_valid = 1'b1;
        mem_resp_data = 128'h22;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (dc_resp_valid !== 1'b1 || dc_resp_data !== 128'h22) begin n_fail++; $display("FAIL spur_real_resp: got v=%b d=%h want 1 22", dc_resp_valid, dc_resp_data); end
    endtask
    initial begin
        test_reset();
        test_ic_fill();
        test_arbitration();
        test_writeback();
        test_kill();
        test_reset_mid();
        test_spurious();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
